tdm_demux_2: RTL
================

# tdm_demux_2

Receive-side two-channel time-division demultiplexer: the far end of the 2:1 channel mux path. It takes the single serial bit stream produced by the transmit mux, locks to a frame-sync marker, and deinterleaves the alternating word slots back into two parallel channel words. Each word is presented with a one-cycle valid strobe. The block sits between the serial link input and the per-channel consumers.

## Interface
Parameters:
- WORD_W, 8, bits per channel word (legal range 2..32)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- din  in  1  serial data bit, MSB first within each word
- din_valid  in  1  din/fsync are sampled only when high
- fsync  in  1  frame marker; high with the first bit of slot 0
- ch0_data  out  WORD_W  last completed channel-0 word
- ch0_valid  out  1  one-cycle strobe, ch0_data updated
- ch1_data  out  WORD_W  last completed channel-1 word
- ch1_valid  out  1  one-cycle strobe, ch1_data updated
- ch0_perr / ch1_perr  out  1  parity error flag, qualified by chN_valid (see Configuration)
- locked  out  1  high while in SLOT0/SLOT1
- sync_err  out  1  one-cycle strobe on framing violation

## Operation
- Frame = slot 0 (channel 0) followed by slot 1 (channel 1). Each slot is S bits: S = WORD_W, or S = WORD_W+1 with parity enabled.
- States:
  - HUNT: locked=0; wait for a sample with fsync=1.
  - SLOT0 / SLOT1: locked=1.
  - A bit counter 0..S-1 plus a WORD_W shift register per active slot.
- HUNT → SLOT0 on a sample with fsync=1. That bit is bit 0 of slot 0, so the counter is 1 after it.
- SLOT0, last bit (counter S-1) → SLOT1. Counter resets to 0. The assembled word loads into ch0_data and ch0_valid pulses.
- SLOT1, last bit → SLOT0. ch1_data loads and ch1_valid pulses. The next sample must carry fsync=1.
- Sample at bit 0 of slot 0 with fsync=0: pulse sync_err and go to HUNT. The sample is discarded.
- fsync=1 at any position other than bit 0 of slot 0:
  - pulse sync_err and abandon the partial word; no valid strobe for it.
  - treat the sample as bit 0 of a new slot 0 (immediate resync, stays locked).
- din_valid=0: state, counter and shift registers hold. fsync and din are ignored.
- chN_data holds its value until the next completed word for that channel.
- Reset (any cycle, including mid-frame): state=HUNT, counter=0, shift registers=0. All outputs reset to 0: ch0_data, ch1_data, ch0_valid, ch1_valid, ch0_perr, ch1_perr, locked, sync_err.

## Timing
- All outputs are registered.
- chN_valid/chN_data update on the clock edge that samples the last bit of the slot, i.e. visible the cycle after that bit is presented.
- sync_err is asserted the cycle after the offending sample.
- locked rises the cycle after the accepted fsync sample. It falls the cycle after a missing-fsync detection.
- Throughput: one bit per cycle with din_valid held high. Gaps of any length are tolerated.
- Valid strobes are never asserted on two consecutive cycles for the same channel. ch0_valid and ch1_valid are never simultaneous.

## Configuration
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - each slot carries WORD_W data bits followed by one even-parity bit over those data bits (S = WORD_W+1).
  - chN_perr is set with chN_valid when the received parity mismatches.
  - data is delivered regardless of the parity result.
- Undefined:
  - S = WORD_W and no parity logic is built.
  - ch0_perr and ch1_perr are tied to 0.

## Test plan
- WORD_W=8, no parity, continuous valid, frame fsync+0xA5 then 0x3C:
  - ch0_valid one cycle after the 8th bit with ch0_data=0xA5.
  - ch1_valid 8 cycles later with ch1_data=0x3C.
  - locked=1 throughout; sync_err never asserted.
- Same frame with din_valid deasserted 3 cycles after every 2nd bit → identical words and strobes, stretched in time; no sync_err.
- Second frame sent without fsync on its first bit:
  - sync_err pulses once and locked drops.
  - no strobes until the next fsync.
  - a following fsync+0x11,0x22 frame then decodes correctly.
- fsync asserted at bit 5 of slot 1:
  - sync_err pulses and no ch1_valid for that slot.
  - the 8 bits from that sample decode as ch0_data.
- rst_n low for one cycle mid-slot 0: all outputs 0 the next cycle, state HUNT; the next fsync frame decodes normally.
- TDM_DEMUX_PARITY_EN, word 0x07 sent with parity bit 0 (wrong) → ch0_valid=1, ch0_data=0x07, ch0_perr=1; word 0x07 with parity 1 → ch0_perr=0.

Source files
------------

// File: rtl/tdm_demux_2.sv
// Two-channel TDM receive demultiplexer: locks to fsync and splits alternating slots into two words.
// Optional per-slot even parity is built when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux_2 #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              fsync,
  output logic [WORD_W-1:0] ch0_data,
  output logic              ch0_valid,
  output logic [WORD_W-1:0] ch1_data,
  output logic              ch1_valid,
  output logic              ch0_perr,
  output logic              ch1_perr,
  output logic              locked,
  output logic              sync_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int S = WORD_W + 1;
`else
  localparam int S = WORD_W;
`endif
  localparam logic [5:0] LAST = 6'(S - 1);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] SLOT0 = 2'd1;
  localparam logic [1:0] SLOT1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] ch0_data_q, ch0_data_d, ch1_data_q, ch1_data_d;
  logic              ch0_valid_q, ch0_valid_d, ch1_valid_q, ch1_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              locked_q;
  logic              take, restart, done0, done1;
  logic [5:0]        pos;
`ifdef TDM_DEMUX_PARITY_EN
  logic              par_q, par_d;
  logic              ch0_perr_q, ch0_perr_d, ch1_perr_q, ch1_perr_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ch0_data_d  = ch0_data_q;
    ch1_data_d  = ch1_data_q;
    ch0_valid_d = 1'b0;
    ch1_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    take        = 1'b0;
    restart     = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    pos         = cnt_q;
`ifdef TDM_DEMUX_PARITY_EN
    par_d       = par_q;
    ch0_perr_d  = ch0_perr_q;
    ch1_perr_d  = ch1_perr_q;
`endif

    if (din_valid) begin
      case (state_q)
        SLOT0, SLOT1: begin
          if (fsync && !(state_q == SLOT0 && cnt_q == 6'd0)) begin
            // Misplaced marker: drop the partial word and restart on this bit.
            sync_err_d = 1'b1;
            restart    = 1'b1;
          end else if (!fsync && state_q == SLOT0 && cnt_q == 6'd0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            cnt_d      = 6'd0;
          end else begin
            take = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d = 6'd0;
              done0 = (state_q == SLOT0);
              done1 = (state_q == SLOT1);
              state_d = (state_q == SLOT0) ? SLOT1 : SLOT0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        default: restart = fsync;
      endcase
    end

    if (restart) begin
      state_d = SLOT0;
      cnt_d   = 6'd1;
      pos     = 6'd0;
      take    = 1'b1;
    end

    // Data bits land MSB first; a parity bit position never matches a data index.
    if (take) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (pos == 6'(WORD_W - 1 - i)) shift_d[i] = din;
      end
`ifdef TDM_DEMUX_PARITY_EN
      if (pos < 6'(WORD_W)) par_d = (pos == 6'd0) ? din : (par_q ^ din);
`endif
    end

    if (done0) begin
      ch0_data_d  = shift_d;
      ch0_valid_d = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
      ch0_perr_d  = par_q ^ din;
`endif
    end
    if (done1) begin
      ch1_data_d  = shift_d;
      ch1_valid_d = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
      ch1_perr_d  = par_q ^ din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      shift_q     <= '0;
      ch0_data_q  <= '0;
      ch1_data_q  <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ch0_data_q  <= ch0_data_d;
      ch1_data_q  <= ch1_data_d;
      ch0_valid_q <= ch0_valid_d;
      ch1_valid_q <= ch1_valid_d;
      sync_err_q  <= sync_err_d;
      locked_q    <= (state_d == SLOT0) || (state_d == SLOT1);
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      ch0_perr_q <= 1'b0;
      ch1_perr_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      ch0_perr_q <= ch0_perr_d;
      ch1_perr_q <= ch1_perr_d;
    end
  end

  assign ch0_perr = ch0_perr_q;
  assign ch1_perr = ch1_perr_q;
`else
  assign ch0_perr = 1'b0;
  assign ch1_perr = 1'b0;
`endif

  assign ch0_data  = ch0_data_q;
  assign ch0_valid = ch0_valid_q;
  assign ch1_data  = ch1_data_q;
  assign ch1_valid = ch1_valid_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

endmodule
